id_ex_pipe_reg: RTL
===================

// Module: id_ex_pipe_reg
// PURPOSE
//  Parametrised ID->EX pipeline register; successor to the fixed-width ID/EX latch.
//  - Carries control bundles EX/MEM/WB, register addresses Rs/Rt/Rd, operands RD1/RD2 and SignImm.
//  - Adds async reset, a FlushE bubble-insertion input and a per-entry valid bit.
//  - Adds saturating stall and bubble performance counters for the hazard unit and the bench.
// PARAMETERS
//  DATA_W      32  width of RD1, RD2, SignImm
//  REG_W       5   register-address width (Rs/Rt/Rd)
//  EX_W        5   EX control bundle width
//  MEM_W       2   MEM control bundle width
//  WB_W        2   WB control bundle width
//  CNT_W       16  width of each performance counter
//  FLUSH_DATA  1   1: flush also zeroes Rs/Rt/Rd/RD1/RD2/SignImm; 0: flush leaves data fields unchanged
// PORTS
//  clk         in   1       rising-edge clock
//  reset       in   1       asynchronous, active-high reset
//  StallD      in   1       hold all E-side registers
//  FlushE      in   1       load a bubble into E
//  CntClr      in   1       synchronous clear of both counters
//  Valid_D     in   1       D-side instruction is real (not a bubble)
//  EX_D        in   EX_W    EX control, D side
//  MEM_D       in   MEM_W   MEM control, D side
//  WB_D        in   WB_W    WB control, D side
//  Rs_D,Rt_D,Rd_D  in  REG_W  register addresses, D side
//  RD1_D,RD2_D     in  DATA_W register-file read data, D side
//  SignImm_D   in   DATA_W  sign-extended immediate, D side
//  Valid_E     out  1       E-side entry valid
//  EX_E,MEM_E,WB_E          out  EX_W/MEM_W/WB_W  registered control
//  Rs_E,Rt_E,Rd_E           out  REG_W            registered addresses
//  RD1_E,RD2_E,SignImm_E    out  DATA_W           registered data
//  StallCnt    out  CNT_W   number of cycles with StallD=1 and FlushE=0, saturating
//  BubbleCnt   out  CNT_W   number of bubbles loaded into E, saturating
// BEHAVIOUR
//  - Reset: reset=1 forces every output to 0 at once, without waiting for a clock edge.
//    Reset during a stall or flush abandons that operation. First capture happens on the first rising edge after reset deasserts.
//  - Latency: 1 cycle D->E. No combinational path from any input to any output.
//  - Per-edge priority: reset > FlushE > StallD > load.
//  - Load (StallD=0, FlushE=0): every E register takes its D value; Valid_E<=Valid_D.
//  - Stall (StallD=1, FlushE=0): every E register holds its value.
//  - Flush (FlushE=1, any StallD): Valid_E, EX_E, MEM_E and WB_E go to 0.
//    Data fields go to 0 when FLUSH_DATA=1 and hold when FLUSH_DATA=0.
//    A flush during a stall still inserts the bubble (load-use case).
//  - A bubble has WB_E=0 and MEM_E=0, so it never writes the register file or memory.
//  - Loading Valid_D=0 is a pass-through bubble: D values are loaded as usual; it is not counted in BubbleCnt.
//  - StallCnt increments when StallD=1 and FlushE=0.
//  - BubbleCnt increments on each FlushE=1 edge.
//  - Both counters saturate at 2^CNT_W-1 with no wrap-around.
//  - CntClr=1 zeroes both counters on the edge and takes priority over increment. It does not affect pipeline fields.
//  - No internal state machine; the state is the E register plus two counters.
// STRUCTURE
//  - Shared package cpu_pipe_pkg holds the default widths (DATA_W, REG_W, EX_W, MEM_W, WB_W)
//    and a packed typedef ctrl_bundle_t {EX, MEM, WB}, reused by the EX_MEM/MEM_WB successors.
//  - Sub-module pipe_field_reg #(W, CLR_ON_FLUSH): async-reset W-bit register with en/clr inputs.
//    Instantiate it once for control+valid (CLR_ON_FLUSH=1) and once for data (CLR_ON_FLUSH=FLUSH_DATA).
//  - Counters are written inline in the top module.
// TESTING
//  1. Assert reset mid-cycle after a load of RD1_D=0xDEADBEEF -> all outputs read 0 before the next edge.
//  2. Load EX_D=5'b10101, WB_D=2'b11, RD1_D=0x12345678, Valid_D=1 -> one edge later EX_E=10101, WB_E=11,
//     RD1_E=0x12345678, Valid_E=1.
//  3. StallD=1 for 3 edges while the D inputs change -> E outputs unchanged, StallCnt=3, BubbleCnt=0.
//  4. StallD=1 and FlushE=1 on the same edge -> Valid_E=0, EX_E=MEM_E=WB_E=0, StallCnt unchanged,
//     BubbleCnt+1. With FLUSH_DATA=0, RD1_E keeps its old value.
//  5. Run with CNT_W=2 and 5 stall edges -> StallCnt=3 (saturated). Then CntClr=1 together with StallD=1
//     -> StallCnt=0.
//  6. Random StallD/FlushE/Valid_D against a reference model for 10k cycles -> E outputs match every cycle.

Source files
------------

// File: rtl/cpu_pipe_pkg.sv
// Shared widths and control-bundle layout for the ID/EX, EX/MEM and MEM/WB
// pipeline registers.
package cpu_pipe_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int EX_W   = 5;
  localparam int MEM_W  = 2;
  localparam int WB_W   = 2;

  // Control travels as one packed bundle so later stages can peel off
  // the part they consume and forward the rest.
  typedef struct packed {
    logic [EX_W-1:0]  ex;
    logic [MEM_W-1:0] mem;
    logic [WB_W-1:0]  wb;
  } ctrl_bundle_t;

endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// D-side inputs and E-side outputs of the ID/EX register.
// Handshake: there is no valid/ready pair here; StallD holds E, FlushE
// loads a bubble into E (flush wins over stall), and Valid_D/Valid_E tag
// whether the carried instruction is real. Every E output is registered.
interface id_ex_pipe_reg_if #(
  parameter int DATA_W = cpu_pipe_pkg::DATA_W,
  parameter int REG_W  = cpu_pipe_pkg::REG_W,
  parameter int EX_W   = cpu_pipe_pkg::EX_W,
  parameter int MEM_W  = cpu_pipe_pkg::MEM_W,
  parameter int WB_W   = cpu_pipe_pkg::WB_W,
  parameter int CNT_W  = 16
);
  logic              StallD;
  logic              FlushE;
  logic              CntClr;
  logic              Valid_D;
  logic [EX_W-1:0]   EX_D;
  logic [MEM_W-1:0]  MEM_D;
  logic [WB_W-1:0]   WB_D;
  logic [REG_W-1:0]  Rs_D, Rt_D, Rd_D;
  logic [DATA_W-1:0] RD1_D, RD2_D, SignImm_D;

  logic              Valid_E;
  logic [EX_W-1:0]   EX_E;
  logic [MEM_W-1:0]  MEM_E;
  logic [WB_W-1:0]   WB_E;
  logic [REG_W-1:0]  Rs_E, Rt_E, Rd_E;
  logic [DATA_W-1:0] RD1_E, RD2_E, SignImm_E;
  logic [CNT_W-1:0]  StallCnt, BubbleCnt;

  // Upstream (decode / hazard unit) side.
  modport master (
    output StallD, FlushE, CntClr, Valid_D, EX_D, MEM_D, WB_D,
           Rs_D, Rt_D, Rd_D, RD1_D, RD2_D, SignImm_D,
    input  Valid_E, EX_E, MEM_E, WB_E, Rs_E, Rt_E, Rd_E,
           RD1_E, RD2_E, SignImm_E, StallCnt, BubbleCnt
  );

  // Pipeline-register side.
  modport slave (
    input  StallD, FlushE, CntClr, Valid_D, EX_D, MEM_D, WB_D,
           Rs_D, Rt_D, Rd_D, RD1_D, RD2_D, SignImm_D,
    output Valid_E, EX_E, MEM_E, WB_E, Rs_E, Rt_E, Rd_E,
           RD1_E, RD2_E, SignImm_E, StallCnt, BubbleCnt
  );
endinterface

// File: rtl/pipe_field_reg.sv
// W-bit pipeline field with async reset, load enable and flush clear.
// When CLR_ON_FLUSH is 0 the clear is ignored and the field simply holds.
module pipe_field_reg #(
  parameter int W            = 8,
  parameter bit CLR_ON_FLUSH = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Reset beats clear beats load; otherwise hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clr && CLR_ON_FLUSH) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register with bubble insertion, valid bit and
// saturating stall/bubble performance counters.
module id_ex_pipe_reg #(
  parameter int DATA_W     = cpu_pipe_pkg::DATA_W,
  parameter int REG_W      = cpu_pipe_pkg::REG_W,
  parameter int EX_W       = cpu_pipe_pkg::EX_W,
  parameter int MEM_W      = cpu_pipe_pkg::MEM_W,
  parameter int WB_W       = cpu_pipe_pkg::WB_W,
  parameter int CNT_W      = 16,
  parameter bit FLUSH_DATA = 1'b1
) (
  input logic               clk,
  input logic               reset,
  id_ex_pipe_reg_if.slave   bus
);
  import cpu_pipe_pkg::*;

  localparam int CTRL_W = 1 + EX_W + MEM_W + WB_W;
  localparam int DAT_W  = 3 * REG_W + 3 * DATA_W;

  logic              load_en;
  logic [CTRL_W-1:0] ctrl_d, ctrl_q;
  logic [DAT_W-1:0]  data_d, data_q;
  logic [CNT_W-1:0]  stall_cnt, bubble_cnt;

  // A flush overrides a stall, so loading needs both quiet.
  assign load_en = !bus.StallD && !bus.FlushE;

  assign ctrl_d = {bus.Valid_D, bus.EX_D, bus.MEM_D, bus.WB_D};
  assign data_d = {bus.Rs_D, bus.Rt_D, bus.Rd_D,
                   bus.RD1_D, bus.RD2_D, bus.SignImm_D};

  // Valid and control always clear on flush so a bubble never writes back.
  pipe_field_reg #(.W(CTRL_W), .CLR_ON_FLUSH(1'b1)) u_ctrl_reg (
    .clk   (clk),
    .reset (reset),
    .en    (load_en),
    .clr   (bus.FlushE),
    .d     (ctrl_d),
    .q     (ctrl_q)
  );

  pipe_field_reg #(.W(DAT_W), .CLR_ON_FLUSH(FLUSH_DATA)) u_data_reg (
    .clk   (clk),
    .reset (reset),
    .en    (load_en),
    .clr   (bus.FlushE),
    .d     (data_d),
    .q     (data_q)
  );

  assign {bus.Valid_E, bus.EX_E, bus.MEM_E, bus.WB_E} = ctrl_q;
  assign {bus.Rs_E, bus.Rt_E, bus.Rd_E,
          bus.RD1_E, bus.RD2_E, bus.SignImm_E} = data_q;

  // Stall counter: cycles held without a flush, saturating, clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (bus.CntClr) begin
      stall_cnt <= '0;
    end else if (bus.StallD && !bus.FlushE && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  // Bubble counter: one per flush edge, saturating, clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bubble_cnt <= '0;
    end else if (bus.CntClr) begin
      bubble_cnt <= '0;
    end else if (bus.FlushE && (bubble_cnt != {CNT_W{1'b1}})) begin
      bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

  assign bus.StallCnt  = stall_cnt;
  assign bus.BubbleCnt = bubble_cnt;

endmodule
